// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the round-robin parallel-to-serial scheduler.
package p2s_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 4;

    // Bit-counter width; a one-bit word still needs a one-bit counter.
    function automatic int cnt_width(input int width);
        if ($clog2(width) > 1) begin
            cnt_width = $clog2(width);
        end else begin
            cnt_width = 1;
        end
    endfunction

endpackage

// File: rtl/p2s_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    input  logic                     en,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int PW = $clog2(N_REQ);

    logic [PW:0]   sum_s;
    logic [PW-1:0] cand_s;
    logic          found_s;

    // Walk requesters in rotated order and keep the first one that is set.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s = {1'b0, ptr} + (PW+1)'(i);
            if (sum_s >= (PW+1)'(N_REQ)) begin
                cand_s = PW'(sum_s - (PW+1)'(N_REQ));
            end else begin
                cand_s = sum_s[PW-1:0];
            end
            if (en && !found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/p2s_rr_scheduler.sv
// Shares one serial lane among N_REQ word producers: round-robin grant, capture,
// then shift one bit per clock, re-arbitrating on the last bit so there is no gap.
module p2s_rr_scheduler
    import p2s_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*WIDTH-1:0]   data_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic                     serial_o,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] src_o,
    output logic                     last_o,
    output logic                     busy_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(N_REQ - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    state_t            state_r, state_n;
    logic [WIDTH-1:0]  shift_r, shift_n;
    logic [CW-1:0]     cnt_r, cnt_n;
    logic [PW-1:0]     ptr_r, ptr_n;
    logic [PW-1:0]     src_r, src_n;
    logic [N_REQ-1:0]  ack_r, ack_n;
    logic              serial_r, serial_n;
    logic              valid_r, valid_n;
    logic              last_r, last_n;

    logic [WIDTH-1:0]  words_s [N_REQ];
    logic [N_REQ-1:0]  grant_s;
    logic [PW-1:0]     idx_s;
    logic              arb_en_s;
    logic              any_s;
    logic [WIDTH-1:0]  win_word_s;
    logic              first_bit_s;
    logic [WIDTH-1:0]  rest_s;
    logic              next_bit_s;
    logic [WIDTH-1:0]  adv_s;

    for (genvar k = 0; k < N_REQ; k++) begin : g_words
        assign words_s[k] = data_i[k*WIDTH +: WIDTH];
    end

    assign arb_en_s = (state_r == IDLE) || ((state_r == SHIFT) && (cnt_r == LAST_CNT));

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req_i),
        .ptr   (ptr_r),
        .en    (arb_en_s),
        .grant (grant_s),
        .idx   (idx_s)
    );

    assign any_s      = |grant_s;
    assign win_word_s = words_s[idx_s];

    // Bit selection for the freshly captured word and for the word already in flight.
    always_comb begin
        first_bit_s = 1'b0;
        rest_s      = '0;
        next_bit_s  = 1'b0;
        adv_s       = '0;
        if (MSB_FIRST != 0) begin
            first_bit_s = win_word_s[WIDTH-1];
            rest_s      = win_word_s << 1'b1;
            next_bit_s  = shift_r[WIDTH-1];
            adv_s       = shift_r << 1'b1;
        end else begin
            first_bit_s = win_word_s[0];
            rest_s      = win_word_s >> 1'b1;
            next_bit_s  = shift_r[0];
            adv_s       = shift_r >> 1'b1;
        end
    end

    // Next-state and next-output logic; every output is the registered copy of these.
    always_comb begin
        state_n  = state_r;
        shift_n  = shift_r;
        cnt_n    = cnt_r;
        ptr_n    = ptr_r;
        src_n    = '0;
        ack_n    = '0;
        serial_n = 1'b0;
        valid_n  = 1'b0;
        last_n   = 1'b0;
        if (arb_en_s && any_s) begin
            state_n  = SHIFT;
            shift_n  = rest_s;
            cnt_n    = '0;
            ptr_n    = (idx_s == LAST_PTR) ? '0 : idx_s + PTR_ONE;
            src_n    = idx_s;
            ack_n    = grant_s;
            serial_n = first_bit_s;
            valid_n  = 1'b1;
            last_n   = (LAST_CNT == '0);
        end else begin
            case (state_r)
                IDLE: begin
                    state_n = IDLE;
                end
                SHIFT: begin
                    if (cnt_r == LAST_CNT) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n    = cnt_r + CNT_ONE;
                        shift_n  = adv_s;
                        src_n    = src_r;
                        serial_n = next_bit_s;
                        valid_n  = 1'b1;
                        last_n   = ((cnt_r + CNT_ONE) == LAST_CNT);
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            shift_r  <= '0;
            cnt_r    <= '0;
            ptr_r    <= '0;
            src_r    <= '0;
            ack_r    <= '0;
            serial_r <= 1'b0;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            shift_r  <= shift_n;
            cnt_r    <= cnt_n;
            ptr_r    <= ptr_n;
            src_r    <= src_n;
            ack_r    <= ack_n;
            serial_r <= serial_n;
            valid_r  <= valid_n;
            last_r   <= last_n;
        end
    end

    assign ack_o    = ack_r;
    assign serial_o = serial_r;
    assign valid_o  = valid_r;
    assign src_o    = src_r;
    assign last_o   = last_r;
    assign busy_o   = valid_r;

endmodule
